// File: rtl/function_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// function_sweep_ctrl
//
// Walks the select/data inputs of a combinational function block through all
// eight input combinations, samples the block's output F once each vector has
// settled, builds the captured truth table and compares it against an expected
// table latched when the sweep is accepted.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : level; begins a sweep when the sequencer is idle
//   abort      : level; cancels a running sweep (also beats start in IDLE)
//   exp_table  : expected F per vector index, latched on an accepted start
//   f_in       : F from the function block (same clock domain)
//   s_out      : function-block S; s_out[0] = i[2], s_out[1] = i[1]
//   z_out      : function-block Z; z_out = i[0]
//   busy       : high while a sweep is in progress (SETTLE, SAMPLE, DONE)
//   done       : one-cycle pulse at sweep completion
//   pass       : captured table equals latched expected table
//   table_out  : captured F, bit i = F for vector i
//   mismatch   : table_out XOR latched expected table
//   state_dbg  : current FSM state (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3)
//
// Handshake: start and abort are plain levels sampled on every rising edge;
// there is no ready/ack. A start is accepted only in IDLE with abort low, and
// the result is presented as a single done pulse with pass/mismatch valid in
// that same cycle and held until the next accepted start or reset.
// -----------------------------------------------------------------------------
module function_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 2   // cycles each vector is held before F is sampled, 1..15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] exp_table,
   input  logic       f_in,
   output logic [1:0] s_out,
   output logic       z_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] table_out,
   output logic [7:0] mismatch,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;     // vector index being applied
   logic [3:0] cnt_q, cnt_d;     // settle counter
   logic [2:0] vec_q, vec_d;     // registered vector driven onto s_out/z_out
   logic [7:0] exp_q, exp_d;     // expected table latched at start
   logic [7:0] tbl_q, tbl_d;
   logic [7:0] mm_q, mm_d;
   logic       pass_q, pass_d;
   logic [7:0] tbl_cap;          // table including the bit sampled this cycle

   always_comb begin
      tbl_cap          = tbl_q;
      tbl_cap[idx_q]   = f_in;

      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      tbl_d   = tbl_q;
      mm_d    = mm_q;
      pass_d  = pass_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_SETTLE;
               exp_d   = exp_table;
               idx_d   = 3'd0;
               cnt_d   = 4'd0;
               tbl_d   = 8'h00;
               mm_d    = 8'h00;
               pass_d  = 1'b0;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d = ST_IDLE;
               idx_d   = 3'd0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_SAMPLE: begin
            // abort has priority: the bit of the aborted vector is not captured
            if (abort) begin
               state_d = ST_IDLE;
               idx_d   = 3'd0;
            end else begin
               tbl_d = tbl_cap;
               if (idx_q == 3'd7) begin
                  // Compare on the way into DONE so pass/mismatch are already
                  // valid during the done pulse.
                  state_d = ST_DONE;
                  mm_d    = tbl_cap ^ exp_q;
                  pass_d  = (tbl_cap == exp_q);
               end else begin
                  state_d = ST_SETTLE;
                  idx_d   = idx_q + 3'd1;
                  cnt_d   = 4'd0;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
         end
      endcase

      // The vector is only driven while settling/sampling; zero otherwise.
      vec_d = ((state_d == ST_SETTLE) || (state_d == ST_SAMPLE)) ? idx_d : 3'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= 3'd0;
         cnt_q   <= 4'd0;
         vec_q   <= 3'd0;
         exp_q   <= 8'h00;
         tbl_q   <= 8'h00;
         mm_q    <= 8'h00;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         exp_q   <= exp_d;
         tbl_q   <= tbl_d;
         mm_q    <= mm_d;
         pass_q  <= pass_d;
      end
   end

   assign s_out     = {vec_q[1], vec_q[2]};
   assign z_out     = vec_q[0];
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign pass      = pass_q;
   assign table_out = tbl_q;
   assign mismatch  = mm_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_function_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for function_sweep_ctrl. Two instances: SETTLE_CYCLES=2 (slot 0) and
// SETTLE_CYCLES=1 (slot 1). Each instance's F input comes from a truth table
// looked up with the vector the DUT drives. Drivers push the expected result
// of every sweep (or aborted sweep) into exp_q; the monitor pops and compares
// when the DUT presents it, and also checks busy and the applied vector every
// cycle against a timeline derived from the start edge.
// -----------------------------------------------------------------------------
module tb_function_sweep_ctrl;

   typedef struct packed {
      logic        k;        // instance
      logic        is_done;  // 1: done pulse expected, 0: abort snapshot
      logic [31:0] at;       // cycle at which the event is visible
      logic [7:0]  tbl;
      logic [7:0]  mm;
      logic        ps;
   } ev_t;

   ev_t exp_q[$];

   logic       clk;
   logic       rst_n;
   logic       start     [2];
   logic       abort     [2];
   logic [7:0] exp_tbl   [2];
   logic [7:0] model_tbl [2];
   logic       f_in      [2];
   logic [1:0] s_out     [2];
   logic       z_out     [2];
   logic       busy      [2];
   logic       done      [2];
   logic       pass      [2];
   logic [7:0] table_out [2];
   logic [7:0] mismatch  [2];
   logic [1:0] state_dbg [2];

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int sw_e0  [2];
   int sw_end [2];

   // ---------------- clock / reset / DUTs ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign f_in[g] = model_tbl[g][{s_out[g][0], s_out[g][1], z_out[g]}];
      function_sweep_ctrl #(.SETTLE_CYCLES(g == 0 ? 2 : 1)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start[g]),
         .abort     (abort[g]),
         .exp_table (exp_tbl[g]),
         .f_in      (f_in[g]),
         .s_out     (s_out[g]),
         .z_out     (z_out[g]),
         .busy      (busy[g]),
         .done      (done[g]),
         .pass      (pass[g]),
         .table_out (table_out[g]),
         .mismatch  (mismatch[g]),
         .state_dbg (state_dbg[g])
      );
   end

   function automatic int per(input int k);
      return (k == 0) ? 3 : 2;   // SETTLE_CYCLES + 1
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            int  c;
            int  p;
            bit  exp_busy;
            ev_t e;
            p        = per(k);
            c        = cyc - sw_e0[k];
            exp_busy = (sw_e0[k] >= 0) && (cyc >= sw_e0[k]) && (cyc < sw_end[k]);
            chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(exp_busy));
            if (exp_busy && c < 8 * p)
               chk($sformatf("vector[%0d]", k), 32'({s_out[k][0], s_out[k][1], z_out[k]}), 32'(c / p));
            else if (!exp_busy)
               chk($sformatf("vector_idle[%0d]", k), 32'({s_out[k], z_out[k]}), 32'd0);

            if (exp_q.size() > 0 && exp_q[0].k == 1'(k) && int'(exp_q[0].at) < cyc) begin
               e = exp_q.pop_front();
               chk($sformatf("event_missing[%0d]", k), 32'(cyc), e.at);
            end
            if (exp_q.size() > 0 && exp_q[0].k == 1'(k) && int'(exp_q[0].at) == cyc) begin
               e = exp_q.pop_front();
               chk($sformatf("done[%0d]", k), 32'(done[k]), 32'(e.is_done));
               chk($sformatf("table_out[%0d]", k), 32'(table_out[k]), 32'(e.tbl));
               chk($sformatf("mismatch[%0d]", k), 32'(mismatch[k]), 32'(e.mm));
               chk($sformatf("pass[%0d]", k), 32'(pass[k]), 32'(e.ps));
            end else if (done[k]) begin
               chk($sformatf("unexpected_done[%0d]", k), 32'(done[k]), 32'd0);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check_zero(input int k, input string tag);
      chk({tag, "_s_out"}, 32'(s_out[k]), 32'd0);
      chk({tag, "_z_out"}, 32'(z_out[k]), 32'd0);
      chk({tag, "_busy"}, 32'(busy[k]), 32'd0);
      chk({tag, "_done"}, 32'(done[k]), 32'd0);
      chk({tag, "_pass"}, 32'(pass[k]), 32'd0);
      chk({tag, "_table"}, 32'(table_out[k]), 32'd0);
      chk({tag, "_mismatch"}, 32'(mismatch[k]), 32'd0);
   endtask

   // Issue an accepted start; returns the start edge cycle.
   task automatic begin_sweep(input int k, input logic [7:0] mdl, input logic [7:0] exp,
                              output int e0);
      model_tbl[k] = mdl;
      exp_tbl[k]   = exp;
      start[k]     = 1'b1;
      e0           = cyc + 1;
      sw_e0[k]     = e0;
      sw_end[k]    = e0 + 8 * per(k) + 1;
      tick();
      start[k]   = 1'b0;
      exp_tbl[k] = 8'($urandom);   // must not affect the running sweep
   endtask

   task automatic sweep(input int k, input logic [7:0] mdl, input logic [7:0] exp,
                        input bit extra_start);
      int  e0;
      ev_t e;
      begin_sweep(k, mdl, exp, e0);
      e.k = 1'(k); e.is_done = 1'b1; e.at = 32'(e0 + 8 * per(k));
      e.tbl = mdl; e.mm = mdl ^ exp; e.ps = (mdl == exp);
      exp_q.push_back(e);
      if (extra_start) begin
         repeat ($urandom_range(1, 12)) tick();
         start[k] = 1'b1;
         tick();
         start[k] = 1'b0;
      end
      while (cyc < e0 + 8 * per(k) + 2) tick();
   endtask

   task automatic abort_sweep(input int k, input logic [7:0] mdl, input logic [7:0] exp,
                              input int v, input int off);
      int         e0;
      ev_t        e;
      logic [7:0] mask;
      begin_sweep(k, mdl, exp, e0);
      while (cyc < e0 + v * per(k) + off) tick();
      mask = 8'h00;
      for (int b = 0; b < v; b++) mask[b] = 1'b1;
      abort[k]  = 1'b1;
      sw_end[k] = cyc + 1;
      e.k = 1'(k); e.is_done = 1'b0; e.at = 32'(cyc + 1);
      e.tbl = mdl & mask; e.mm = 8'h00; e.ps = 1'b0;
      exp_q.push_back(e);
      tick();
      abort[k] = 1'b0;
      repeat (3) tick();
   endtask

   task automatic start_abort_idle(input int k);
      exp_tbl[k] = 8'($urandom);
      start[k]   = 1'b1;
      abort[k]   = 1'b1;
      tick();
      start[k]   = 1'b0;
      abort[k]   = 1'b0;
      repeat (3) tick();
   endtask

   task automatic reset_mid_sweep(input int k);
      int e0;
      begin_sweep(k, 8'($urandom), 8'($urandom), e0);
      repeat ($urandom_range(2, 10)) tick();
      #1;
      rst_n = 1'b0;
      #1;
      check_zero(k, "reset_mid");
      exp_q.delete();
      sw_e0[k] = -1;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0; abort[k] = 1'b0; exp_tbl[k] = 8'h00; model_tbl[k] = 8'h00;
         sw_e0[k] = -1; sw_end[k] = -1;
      end
      #3;
      check_zero(0, "reset0");
      check_zero(1, "reset1");
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // SETTLE_CYCLES = 2 instance
      sweep(0, 8'hB4, 8'hB4, 1'b0);
      sweep(0, 8'hB4, 8'hB5, 1'b0);
      abort_sweep(0, 8'hB4, 8'hB4, 3, int'($urandom_range(0, 2)));
      sweep(0, 8'hB4, 8'hB4, 1'b1);
      start_abort_idle(0);
      for (int n = 0; n < 6; n++) begin
         logic [7:0] m;
         m = 8'($urandom);
         sweep(0, m, ($urandom_range(0, 1) == 1) ? m : 8'($urandom), 1'($urandom_range(0, 1)));
      end
      for (int n = 0; n < 3; n++)
         abort_sweep(0, 8'($urandom), 8'($urandom), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 2)));

      // SETTLE_CYCLES = 1 instance
      sweep(1, 8'h3C, 8'h3C, 1'b0);
      start_abort_idle(1);
      for (int n = 0; n < 4; n++) begin
         logic [7:0] m;
         m = 8'($urandom);
         sweep(1, m, ($urandom_range(0, 1) == 1) ? m : 8'($urandom), 1'($urandom_range(0, 1)));
      end
      abort_sweep(1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)));

      reset_mid_sweep(0);
      reset_mid_sweep(1);
      sweep(0, 8'h5A, 8'h5A, 1'b0);

      repeat (3) tick();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
